// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register, IR load, branch/jump and fetch timeout.
// Ports:
//   i_clk          clock, all state updates on posedge
//   i_reset_n      synchronous active-low reset
//   i_pc_we        controller PC write enable
//   i_pc_src       PC source: 0 tgt_reg, 1 alu_result, 2 jump target, 3 hold
//   i_ir_we        request to fetch into the instruction register
//   i_branch       1 = BEQ, 2 = BNE, other = no branch
//   i_alu_result   ALU output
//   i_alu_zero     ALU zero flag
//   i_imem_rdata   instruction memory read data
//   i_imem_ready   instruction memory data valid this cycle
//   o_imem_addr    fetch address (equals pc)
//   o_imem_req     fetch request
//   o_instruction  instruction register
//   o_pc           program counter
//   o_pc_plus4     pc + 4, modulo 2^32
//   o_stall        fetch outstanding, controller must hold
//   o_fetch_err    sticky fetch timeout flag
module fetch_unit #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pc_we,
    input  logic [1:0]  i_pc_src,
    input  logic        i_ir_we,
    input  logic [3:0]  i_branch,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zero,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_stall,
    output logic        o_fetch_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_tgt_reg;
    logic        r_pend_we;
    logic [1:0]  r_pend_src;
    logic [31:0] r_pend_alu;
    logic [3:0]  r_wait_cnt;
    logic        r_fetch_err;

    logic        w_idle;
    logic [1:0]  w_src;
    logic [31:0] w_alu;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_load_pc;
    logic        w_taken;
    logic        w_timeout;

    // In WAIT the PC load is driven from the values captured when the fetch started.
    assign w_idle     = r_state == S_IDLE;
    assign w_src      = w_idle ? i_pc_src : r_pend_src;
    assign w_alu      = w_idle ? i_alu_result : r_pend_alu;
    assign w_pc_plus4 = r_pc + 32'd4;
    // Uses the IR contents before any IR load happening in the same cycle.
    assign w_jump_tgt = {w_pc_plus4[31:28], r_instruction[25:0], 2'b00};
    assign w_taken    = (i_branch == 4'd1 && i_alu_zero) || (i_branch == 4'd2 && !i_alu_zero);
    assign w_timeout  = r_wait_cnt == 4'(WAIT_LIMIT - 1);

    always_comb begin
        w_load_pc = (w_src == 2'd0 ? r_tgt_reg : w_src == 2'd1 ? w_alu : w_jump_tgt) & ~32'd3;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instruction <= '0;
            r_tgt_reg     <= '0;
            r_pend_we     <= 1'b0;
            r_pend_src    <= '0;
            r_pend_alu    <= '0;
            r_wait_cnt    <= '0;
            r_fetch_err   <= 1'b0;
        end else if (w_idle) begin
            if (i_branch != 4'd1 && i_branch != 4'd2)
                r_tgt_reg <= i_alu_result;
            if (i_ir_we && !i_imem_ready) begin
                r_pend_we  <= i_pc_we;
                r_pend_src <= i_pc_src;
                r_pend_alu <= i_alu_result;
                r_wait_cnt <= '0;
                r_state    <= S_WAIT;
            end else begin
                if (i_ir_we)
                    r_instruction <= i_imem_rdata;
                if (i_pc_we) begin
                    if (i_pc_src != 2'd3)
                        r_pc <= w_load_pc;
                end else if (w_taken) begin
                    r_pc <= r_tgt_reg & ~32'd3;
                end
            end
        end else if (i_imem_ready || w_timeout) begin
            // A ready on the final wait cycle completes normally; otherwise abort with a NOP.
            r_instruction <= i_imem_ready ? i_imem_rdata : '0;
            r_fetch_err   <= r_fetch_err | !i_imem_ready;
            if (r_pend_we && r_pend_src != 2'd3)
                r_pc <= w_load_pc;
            r_state <= S_IDLE;
        end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_imem_req    = i_reset_n && (r_state == S_WAIT || i_ir_we);
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_stall       = i_reset_n && r_state == S_WAIT;
    assign o_fetch_err   = r_fetch_err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, per-cycle model comparison and literal checks for fetch_unit.
module tb_fetch_unit;
    localparam int WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pc_we = 1'b0;
    logic [1:0]  pc_src = '0;
    logic        ir_we = 1'b0;
    logic [3:0]  branch = '0;
    logic [31:0] alu = '0;
    logic        zero = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic [31:0] o_imem_addr;
    logic        o_imem_req;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_stall;
    logic        o_fetch_err;

    fetch_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .i_pc_we(pc_we),
        .i_pc_src(pc_src),
        .i_ir_we(ir_we),
        .i_branch(branch),
        .i_alu_result(alu),
        .i_alu_zero(zero),
        .i_imem_rdata(rdata),
        .i_imem_ready(ready),
        .o_imem_addr(o_imem_addr),
        .o_imem_req(o_imem_req),
        .o_instruction(o_instruction),
        .o_pc(o_pc),
        .o_pc_plus4(o_pc_plus4),
        .o_stall(o_stall),
        .o_fetch_err(o_fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Reference model: architectural state plus an "outstanding fetch" record.
    logic [31:0] m_pc, m_ir, m_tgt, p_alu;
    logic        m_err, m_busy, p_we;
    logic [1:0]  p_src;
    int          m_waited;

    function automatic logic [31:0] target(input logic [1:0] s, input logic [31:0] a);
        logic [31:0] nxt;
        nxt = m_pc + 32'd4;
        if (s == 2'd3) return m_pc;
        if (s == 2'd0) return m_tgt & ~32'd3;
        if (s == 2'd1) return a & ~32'd3;
        return {nxt[31:28], m_ir[25:0], 2'b00};
    endfunction

    always @(posedge clk) begin
        logic [31:0] new_pc;
        if (!reset_n) begin
            m_pc = 0; m_ir = 0; m_tgt = 0; m_err = 0; m_busy = 0; m_waited = 0;
            p_we = 0; p_src = 0; p_alu = 0;
        end else if (m_busy) begin
            if (!ready) m_waited++;
            if (ready || m_waited == WAIT_LIMIT) begin
                if (p_we) m_pc = target(p_src, p_alu);
                m_ir = ready ? rdata : 32'h0;
                if (!ready) m_err = 1;
                m_busy = 0;
            end
        end else begin
            if (ir_we && !ready) begin
                m_busy = 1; m_waited = 0; p_we = pc_we; p_src = pc_src; p_alu = alu;
            end else begin
                new_pc = m_pc;
                if (pc_we) new_pc = target(pc_src, alu);
                else if ((branch == 1 && zero) || (branch == 2 && !zero)) new_pc = m_tgt & ~32'd3;
                m_pc = new_pc;
                if (ir_we) m_ir = rdata;
            end
            if (branch != 1 && branch != 2) m_tgt = alu;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("imem_addr", o_imem_addr, m_pc);
            chk("pc", o_pc, m_pc);
            chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
            chk("instruction", o_instruction, m_ir);
            chk("fetch_err", {31'b0, o_fetch_err}, {31'b0, m_err});
            chk("stall", {31'b0, o_stall}, {31'b0, reset_n && m_busy});
            chk("imem_req", {31'b0, o_imem_req}, {31'b0, reset_n && (m_busy || ir_we)});
        end
    end

    task automatic drv(input logic iw, input logic pw, input logic [1:0] s, input logic [31:0] a,
                       input logic [3:0] b, input logic z, input logic rdy, input logic [31:0] rd);
        ir_we = iw; pc_we = pw; pc_src = s; alu = a; branch = b; zero = z; ready = rdy; rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_ir", o_instruction, 32'h0);
        chk("rst_err", {31'b0, o_fetch_err}, 32'h0);
        chk("rst_stall", {31'b0, o_stall}, 32'h0);

        drv(1, 1, 1, 32'h4, 0, 0, 1, 32'h8C080004);
        chk("zw_ir", o_instruction, 32'h8C080004);
        chk("zw_pc", o_pc, 32'h4);
        chk("zw_stall", {31'b0, o_stall}, 32'h0);

        drv(1, 1, 1, 32'h8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ws_stall", {31'b0, o_stall}, 32'h1);
            chk("ws_pc_hold", o_pc, 32'h4);
            if (i < 2) drv(0, 1, 0, 32'h123, 1, 1, 0, 0);
        end
        drv(0, 1, 0, 32'h123, 1, 1, 1, 32'h12345678);
        chk("ws_pc", o_pc, 32'h8);
        chk("ws_ir", o_instruction, 32'h12345678);
        chk("ws_stall_end", {31'b0, o_stall}, 32'h0);

        drv(0, 0, 0, 32'h40, 0, 0, 0, 0);
        drv(0, 0, 0, 32'h999, 1, 1, 0, 0);
        chk("beq_taken", o_pc, 32'h40);
        drv(0, 0, 0, 32'h999, 2, 1, 0, 0);
        chk("bne_not_taken", o_pc, 32'h40);
        drv(0, 0, 0, 32'h80, 0, 0, 0, 0);
        drv(0, 0, 0, 32'h5, 2, 0, 0, 0);
        chk("bne_taken", o_pc, 32'h80);
        drv(0, 1, 1, 32'h200, 1, 1, 0, 0);
        chk("pcwe_prio", o_pc, 32'h200);

        drv(0, 1, 1, 32'h10000000, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 1, 32'h08000010);
        drv(0, 1, 2, 0, 0, 0, 0, 0);
        chk("jump", o_pc, 32'h10000040);
        drv(1, 1, 2, 0, 0, 0, 1, 32'h08000099);
        chk("jump_old_ir", o_pc, 32'h10000040);
        chk("jump_ir_load", o_instruction, 32'h08000099);
        drv(0, 1, 2, 0, 0, 0, 0, 0);
        chk("jump_new_ir", o_pc, 32'h10000264);
        drv(0, 1, 3, 32'h777, 0, 0, 0, 0);
        chk("src_hold", o_pc, 32'h10000264);
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        chk("src_tgt_align", o_pc, 32'h774);

        drv(0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        chk("align_pc", o_pc, 32'hFFFFFFFC);
        chk("pc4_wrap", o_pc_plus4, 32'h0);

        drv(1, 1, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < WAIT_LIMIT - 1; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("late_stall", {31'b0, o_stall}, 32'h1);
        drv(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        chk("late_ir", o_instruction, 32'hCAFEF00D);
        chk("late_no_err", {31'b0, o_fetch_err}, 32'h0);
        chk("late_pc", o_pc, 32'h100);

        drv(1, 1, 1, 32'h300, 0, 0, 0, 0);
        for (int i = 0; i < WAIT_LIMIT - 1; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_stall", {31'b0, o_stall}, 32'h1);
        drv(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        chk("to_ir", o_instruction, 32'h0);
        chk("to_err", {31'b0, o_fetch_err}, 32'h1);
        chk("to_pc", o_pc, 32'h300);
        chk("to_idle", {31'b0, o_stall}, 32'h0);
        drv(1, 0, 0, 0, 0, 0, 1, 32'hAABBCCDD);
        chk("after_to_ir", o_instruction, 32'hAABBCCDD);
        chk("after_to_err", {31'b0, o_fetch_err}, 32'h1);

        drv(1, 1, 1, 32'h500, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_pc", o_pc, 32'h0);
        chk("mr_ir", o_instruction, 32'h0);
        chk("mr_req", {31'b0, o_imem_req}, 32'h0);
        chk("mr_stall", {31'b0, o_stall}, 32'h0);
        chk("mr_err", {31'b0, o_fetch_err}, 32'h0);
        reset_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_req_after", {31'b0, o_imem_req}, 32'h0);
        chk("mr_stall_after", {31'b0, o_stall}, 32'h0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
